// File: rtl/alarma_sirena.sv
// rtl/alarma_sirena.sv - car-alarm siren driver: entry delay, intermittent siren, max sounding time, lockout, trigger counter
// Optional latched "alarm fired" indicator enabled by defining ALARMA_MEMORIA_EN.
module alarma_sirena #(
    parameter int DELAY  = 4,
    parameter int HALF   = 2,
    parameter int MAX_ON = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       c,
    input  logic       a,
    output logic       sirena,
    output logic       luces,
    output logic [1:0] estado,
    output logic [7:0] disparos
`ifdef ALARMA_MEMORIA_EN
    ,
    output logic       memoria
`endif
);

    localparam int MAX_CNT = (DELAY > MAX_ON) ? DELAY : MAX_ON;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int PW      = $clog2(HALF + 1);

    localparam logic [CW-1:0] DELAY_LD = CW'(DELAY - 1);
    localparam logic [CW-1:0] MAX_LD   = CW'(MAX_ON - 1);
    localparam logic [PW-1:0] HALF_LD  = PW'(HALF - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DELAY = 2'b01,
        ST_SOUND = 2'b10,
        ST_HOLD  = 2'b11
    } state_t;

    state_t          r_estado;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_ph;
    logic            r_sirena;
    logic            r_luces;
    logic [7:0]      r_disparos;

    state_t          w_estado_nx;
    logic [CW-1:0]   w_cnt_nx;
    logic [PW-1:0]   w_ph_nx;
    logic            w_sirena_nx;
    logic            w_luces_nx;
    logic [7:0]      w_disparos_nx;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_estado   <= ST_IDLE;
            r_cnt      <= '0;
            r_ph       <= '0;
            r_sirena   <= 1'b0;
            r_luces    <= 1'b0;
            r_disparos <= 8'd0;
        end else begin
            r_estado   <= w_estado_nx;
            r_cnt      <= w_cnt_nx;
            r_ph       <= w_ph_nx;
            r_sirena   <= w_sirena_nx;
            r_luces    <= w_luces_nx;
            r_disparos <= w_disparos_nx;
        end
    end

    // Outputs are computed for the state being entered so they appear on the transition edge.
    always_comb begin
        w_estado_nx   = r_estado;
        w_cnt_nx      = r_cnt;
        w_ph_nx       = r_ph;
        w_sirena_nx   = 1'b0;
        w_luces_nx    = 1'b0;
        w_disparos_nx = r_disparos;

        if (!c) begin
            w_estado_nx = ST_IDLE;
            w_cnt_nx    = '0;
            w_ph_nx     = '0;
        end else begin
            case (r_estado)
                ST_IDLE: begin
                    if (a) begin
                        w_estado_nx = ST_DELAY;
                        w_cnt_nx    = DELAY_LD;
                        w_luces_nx  = 1'b1;
                        if (r_disparos != 8'hFF) begin
                            w_disparos_nx = r_disparos + 8'd1;
                        end
                    end
                end
                ST_DELAY: begin
                    w_luces_nx = 1'b1;
                    if (r_cnt == '0) begin
                        w_estado_nx = ST_SOUND;
                        w_cnt_nx    = MAX_LD;
                        w_ph_nx     = '0;
                        w_sirena_nx = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt - CW'(1);
                    end
                end
                ST_SOUND: begin
                    if (r_cnt == '0) begin
                        w_estado_nx = ST_HOLD;
                        w_ph_nx     = '0;
                    end else begin
                        w_cnt_nx   = r_cnt - CW'(1);
                        w_luces_nx = 1'b1;
                        // ph counts within one half-period; the siren flips at its end
                        if (r_ph == HALF_LD) begin
                            w_ph_nx     = '0;
                            w_sirena_nx = ~r_sirena;
                        end else begin
                            w_ph_nx     = r_ph + PW'(1);
                            w_sirena_nx = r_sirena;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!a) begin
                        w_estado_nx = ST_IDLE;
                    end
                end
                default: begin
                    w_estado_nx = ST_IDLE;
                end
            endcase
        end
    end

    assign sirena   = r_sirena;
    assign luces    = r_luces;
    assign estado   = r_estado;
    assign disparos = r_disparos;

`ifdef ALARMA_MEMORIA_EN
    logic r_c_prev;
    logic r_memoria;

    // Arming (rising c) clears the memory; entering SOUND sets it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_c_prev  <= 1'b0;
            r_memoria <= 1'b0;
        end else begin
            r_c_prev <= c;
            if (c && !r_c_prev) begin
                r_memoria <= 1'b0;
            end else if (r_estado == ST_DELAY && w_estado_nx == ST_SOUND) begin
                r_memoria <= 1'b1;
            end
        end
    end

    assign memoria = r_memoria;
`endif

endmodule

// File: tb/tb_alarma_sirena.sv
// tb/tb_alarma_sirena.sv - self-checking bench for alarma_sirena (vectors, corner sequences, random vs model)
module tb_alarma_sirena;

    localparam int DELAY  = 4;
    localparam int HALF   = 2;
    localparam int MAX_ON = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       c = 1'b0;
    logic       a = 1'b0;
    logic       sirena;
    logic       luces;
    logic [1:0] estado;
    logic [7:0] disparos;
`ifdef ALARMA_MEMORIA_EN
    logic       memoria;
`endif

    int n_cmp = 0;
    int n_err = 0;

    alarma_sirena #(.DELAY(DELAY), .HALF(HALF), .MAX_ON(MAX_ON)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .c        (c),
        .a        (a),
        .sirena   (sirena),
        .luces    (luces),
        .estado   (estado),
        .disparos (disparos)
`ifdef ALARMA_MEMORIA_EN
        ,
        .memoria  (memoria)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: time since trigger, not a state machine
    bit m_active, m_hold, m_mem, m_cprev;
    int m_t, m_cnt;

    function automatic void model_step(bit rn, bit cc, bit aa);
        if (!rn) begin
            m_active = 0; m_hold = 0; m_t = 0; m_cnt = 0; m_mem = 0;
        end else if (!cc) begin
            m_active = 0; m_hold = 0;
        end else if (m_hold) begin
            if (!aa) m_hold = 0;
        end else if (m_active) begin
            m_t++;
            if (m_t == DELAY + MAX_ON) begin
                m_active = 0; m_hold = 1;
            end
        end else if (aa) begin
            m_active = 1; m_t = 0;
            if (m_cnt < 255) m_cnt++;
        end
        if (rn && cc && !m_cprev) m_mem = 0;
        else if (rn && m_active && m_t == DELAY) m_mem = 1;
        m_cprev = rn ? cc : 1'b0;
    endfunction

    function automatic int m_estado();
        if (m_active) return (m_t < DELAY) ? 1 : 2;
        return m_hold ? 3 : 0;
    endfunction

    function automatic int m_sirena();
        if (m_active && m_t >= DELAY) return (((m_t - DELAY) / HALF) % 2 == 0) ? 1 : 0;
        return 0;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(bit rn, bit cc, bit aa);
        reset_n = rn; c = cc; a = aa;
        @(posedge clk);
        model_step(rn, cc, aa);
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick(0, 1, 0);
        tick(0, 1, 0);
    endtask

    typedef struct {
        bit       rn, c, a;
        int       e, s, l, d;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(bit rn, bit cc, bit aa, int e, int s, int l, int d);
        vec_t v;
        v.rn = rn; v.c = cc; v.a = aa; v.e = e; v.s = s; v.l = l; v.d = d;
        return v;
    endfunction

    initial begin
        // Reset with c=a=1, single a pulse, full delay/sound/hold/idle cycle
        vecs[0] = mk(0, 1, 1, 0, 0, 0, 0);
        vecs[1] = mk(0, 1, 1, 0, 0, 0, 0);
        vecs[2] = mk(1, 1, 1, 1, 0, 1, 1);
        vecs[3] = mk(1, 1, 0, 1, 0, 1, 1);
        vecs[4] = mk(1, 1, 0, 1, 0, 1, 1);
        vecs[5] = mk(1, 1, 0, 1, 0, 1, 1);
        for (int i = 6; i < 22; i++)
            vecs[i] = mk(1, 1, 0, 2, (((i - 6) / 2) % 2 == 0) ? 1 : 0, 1, 1);
        vecs[22] = mk(1, 1, 0, 3, 0, 0, 1);
        vecs[23] = mk(1, 1, 0, 0, 0, 0, 1);

        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            tick(vecs[i].rn, vecs[i].c, vecs[i].a);
            chk($sformatf("vec%0d estado", i), int'(estado), vecs[i].e);
            chk($sformatf("vec%0d sirena", i), int'(sirena), vecs[i].s);
            chk($sformatf("vec%0d luces", i), int'(luces), vecs[i].l);
            chk($sformatf("vec%0d disparos", i), int'(disparos), vecs[i].d);
        end

`ifdef ALARMA_MEMORIA_EN
        chk("memoria set after run", int'(memoria), 1);
        tick(1, 0, 0);
        chk("memoria held c=0", int'(memoria), 1);
        tick(1, 1, 0);
        chk("memoria cleared on arm", int'(memoria), 0);
`endif

        // Sustained a: lockout holds, no retrigger
        do_reset();
        tick(1, 1, 1);
        for (int i = 0; i < DELAY + MAX_ON; i++) tick(1, 1, 1);
        chk("held a -> HOLD", int'(estado), 3);
        for (int i = 0; i < 5; i++) tick(1, 1, 1);
        chk("held a stays HOLD", int'(estado), 3);
        chk("held a disparos", int'(disparos), 1);
        tick(1, 1, 0);
        chk("a released -> IDLE", int'(estado), 0);
        chk("no retrigger disparos", int'(disparos), 1);

        // c drop during cycle 5 of SOUND
        do_reset();
        tick(1, 1, 1);
        for (int i = 0; i < DELAY; i++) tick(1, 1, 0);
        chk("entered SOUND", int'(estado), 2);
        chk("sirena on entry", int'(sirena), 1);
        for (int i = 0; i < 4; i++) tick(1, 1, 0);
        tick(1, 0, 0);
        chk("disarm estado", int'(estado), 0);
        chk("disarm sirena", int'(sirena), 0);
        chk("disarm luces", int'(luces), 0);
        chk("disarm disparos", int'(disparos), 1);

        // Saturation of trigger counter
        do_reset();
        for (int k = 0; k < 260; k++) begin
            tick(1, 1, 1);
            for (int i = 0; i < DELAY + MAX_ON + 1; i++) tick(1, 1, 0);
            if (k == 254) chk("disparos at 255", int'(disparos), 255);
        end
        chk("disparos saturated", int'(disparos), 255);
        chk("idle after runs", int'(estado), 0);

        // Random stimulus against the model
        do_reset();
        begin
            bit hold_a = 0;
            for (int i = 0; i < 4000; i++) begin
                bit rn, cc;
                rn = ($urandom_range(0, 299) != 0);
                cc = ($urandom_range(0, 59) != 0);
                if ($urandom_range(0, 9) == 0) hold_a = ~hold_a;
                tick(rn, cc, hold_a & ($urandom_range(0, 3) != 0));
                chk("rnd estado", int'(estado), m_estado());
                chk("rnd sirena", int'(sirena), m_sirena());
                chk("rnd luces", int'(luces), int'(m_active));
                chk("rnd disparos", int'(disparos), m_cnt);
`ifdef ALARMA_MEMORIA_EN
                chk("rnd memoria", int'(memoria), int'(m_mem));
`endif
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
